// File: rtl/if_id_stage.sv
// if_id_stage: fetch-to-decode pipeline register built as a 2-entry skid buffer with flush
// Ports: clk/rst_in (async active-low) clock and reset;
//   if_instruction/if_pc/if_pc_add_4/if_valid in, if_ready out: fetch-side handshake;
//   flush in: redirect squash; id_ready in, id_valid/id_instruction/id_pc/id_pc_add_4 out: decode-side handshake;
//   occupancy out: number of valid entries.
module if_id_stage #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst_in,
  input  logic [XLEN-1:0] if_instruction,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_pc_add_4,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic            flush,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instruction,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_add_4,
  output logic [1:0]      occupancy
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t          cnt_q, cnt_d;
  logic            head_q, head_d, tail_q, tail_d;
  logic            push, pop;
  logic [XLEN-1:0] instr_q [2];
  logic [XLEN-1:0] pc_q    [2];
  logic [XLEN-1:0] pc4_q   [2];
  assign if_ready       = cnt_q != TWO;
  assign id_valid       = cnt_q != EMPTY;
  assign occupancy      = cnt_q;
  assign push           = if_valid & if_ready;
  assign pop            = id_valid & id_ready;
  // forced constants when empty keep decode free of stale or X slot data
  assign id_instruction = id_valid ? instr_q[head_q] : NOP_INSTR;
  assign id_pc          = id_valid ? pc_q[head_q]    : '0;
  assign id_pc_add_4    = id_valid ? pc4_q[head_q]   : '0;
  always_comb begin
    cnt_d  = flush ? EMPTY
           : cnt_q == EMPTY ? (push ? ONE : EMPTY)
           : cnt_q == ONE   ? ((push & ~pop) ? TWO : (pop & ~push) ? EMPTY : ONE)
           : (pop ? ONE : TWO);
    head_d = flush ? 1'b0 : head_q ^ pop;
    tail_d = flush ? 1'b0 : tail_q ^ push;
  end
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q  <= EMPTY;
      head_q <= 1'b0;
      tail_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= NOP_INSTR;
        pc_q[i]    <= '0;
        pc4_q[i]   <= '0;
      end
    end else if (push && !flush) begin
      instr_q[tail_q] <= if_instruction;
      pc_q[tail_q]    <= if_pc;
      pc4_q[tail_q]   <= if_pc_add_4;
    end
  end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: scoreboard bench for the fetch/decode skid buffer
module tb_if_id_stage;
  localparam logic [31:0] NOP = 32'h00000013;
  typedef struct {logic [31:0] i; logic [31:0] p; logic [31:0] p4;} ent_t;
  logic        clk = 1'b0;
  logic        rst_in;
  logic [31:0] if_instruction, if_pc, if_pc_add_4;
  logic        if_valid, if_ready, flush, id_ready, id_valid;
  logic [31:0] id_instruction, id_pc, id_pc_add_4;
  logic [1:0]  occupancy;
  ent_t        q[$];
  ent_t        e;
  int          checks = 0;
  int          failures = 0;
  always #5 clk = ~clk;
  if_id_stage dut (
    .clk(clk), .rst_in(rst_in),
    .if_instruction(if_instruction), .if_pc(if_pc), .if_pc_add_4(if_pc_add_4),
    .if_valid(if_valid), .if_ready(if_ready), .flush(flush),
    .id_ready(id_ready), .id_valid(id_valid), .id_instruction(id_instruction),
    .id_pc(id_pc), .id_pc_add_4(id_pc_add_4), .occupancy(occupancy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_outputs();
    int n = q.size();
    chk("occupancy", {30'd0, occupancy}, n);
    chk("if_ready", {31'd0, if_ready}, {31'd0, n != 2});
    chk("id_valid", {31'd0, id_valid}, {31'd0, n != 0});
    chk("id_instruction", id_instruction, n != 0 ? q[0].i : NOP);
    chk("id_pc", id_pc, n != 0 ? q[0].p : 32'd0);
    chk("id_pc_add_4", id_pc_add_4, n != 0 ? q[0].p4 : 32'd0);
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    if_valid       = v;
    if_pc          = pc;
    if_pc_add_4    = pc + 32'd4;
    if_instruction = 32'hA000_0093 | (pc << 12);
    id_ready       = rdy;
    flush          = fl;
  endtask
  task automatic step(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    int n;
    drive(v, pc, rdy, fl);
    @(negedge clk);
    check_outputs();
    n = q.size();
    if (fl) q.delete();
    else begin
      if (n != 0 && rdy) e = q.pop_front();
      if (v && n != 2) q.push_back('{i: if_instruction, p: if_pc, p4: if_pc_add_4});
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_in = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_outputs();
    repeat (3) @(posedge clk);
    #1 rst_in = 1'b1;
    // stream with decode always ready
    step(1'b1, 32'h0, 1'b1, 1'b0);
    chk("t1_instr0", id_instruction, 32'h00500093 ^ 32'h00500093 ^ (32'hA000_0093));
    step(1'b1, 32'h4, 1'b1, 1'b0);
    chk("t1_pc4_1", id_pc_add_4, 32'h8);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    // decode stall, fill, third offer refused, then drain in order
    step(1'b1, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h4, 1'b0, 1'b0);
    chk("t2_full", {30'd0, occupancy}, 32'd2);
    step(1'b1, 32'h8, 1'b0, 1'b0);
    step(1'b1, 32'h8, 1'b1, 1'b0);
    chk("t2_head_after_pop", id_pc, 32'h4);
    step(1'b1, 32'h8, 1'b1, 1'b0);
    chk("t2_last", id_pc, 32'h8);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    // simultaneous push and pop at count 1
    step(1'b1, 32'h10, 1'b0, 1'b0);
    step(1'b1, 32'h14, 1'b1, 1'b0);
    chk("t3_pc", id_pc, 32'h14);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    // flush while full with a concurrent offer
    step(1'b1, 32'h20, 1'b0, 1'b0);
    step(1'b1, 32'h24, 1'b0, 1'b0);
    step(1'b1, 32'h28, 1'b1, 1'b1);
    chk("t4_nop", id_instruction, NOP);
    step(1'b1, 32'h40, 1'b0, 1'b0);
    chk("t4_head", id_pc, 32'h40);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    // asynchronous reset while full
    step(1'b1, 32'h50, 1'b0, 1'b0);
    step(1'b1, 32'h54, 1'b0, 1'b0);
    #2 rst_in = 1'b0;
    #1;
    q.delete();
    chk("t5_valid", {31'd0, id_valid}, 32'd0);
    chk("t5_occ", {30'd0, occupancy}, 32'd0);
    chk("t5_ready", {31'd0, if_ready}, 32'd1);
    chk("t5_instr", id_instruction, NOP);
    @(posedge clk);
    #1 rst_in = 1'b1;
    step(1'b1, 32'h60, 1'b0, 1'b0);
    chk("t5_first_push", id_pc, 32'h60);
    // ignored strobes: pop while empty, push while full
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t6_empty", {30'd0, occupancy}, 32'd0);
    step(1'b1, 32'h70, 1'b0, 1'b0);
    step(1'b1, 32'h74, 1'b0, 1'b0);
    step(1'b1, 32'h78, 1'b0, 1'b0);
    chk("t6_full_head", id_pc, 32'h70);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    // long random run against the scoreboard
    for (int k = 0; k < 300; k++)
      step(1'($urandom_range(0, 3) != 0), 32'($urandom_range(0, 1023)) << 2,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
